spi_cmd_resp_sdc: RTL and testbench
===================================

Name: spi_cmd_resp_sdc

Overview:
Parametrised SD-card SPI command engine. Generates its own SCK (SPI mode 0) and shifts out a 48-bit command frame (cmd, arg, crc). It then hunts for the response start bit with a bounded NCR timeout and captures an R1 or multi-byte (R3/R7) response. Sits between the SD init/read sequencer and the card pins, and can hold CS across command sequences.

Parameters:
CLK_DIV, 1, i_clk cycles per SCK half-period (>=1); one bit slot = 2*CLK_DIV cycles
GAP_BITS, 8, slots clocked with MOSI=1 between the command's last bit and the start of response search (>=1)
NCR_MAX, 64, maximum slots spent searching for the response start bit before timeout
RESP_MAX_BYTES, 5, largest response length supported
TRAIL_BITS, 8, slots clocked with CS=1 and MOSI=1 after the response when CS is released (>=0)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_we  in  1  start pulse; accepted only when o_busy=0
i_cmd  in  8  command byte (01xxxxxx)
i_arg  in  32  argument
i_crc  in  8  CRC7 plus end bit
i_resp_len  in  3  response bytes; 0 is treated as 1, values >RESP_MAX_BYTES clamp to RESP_MAX_BYTES
i_hold_cs  in  1  1 = keep CS low after completion
i_miso  in  1  card data out
o_sck  out  1  SPI clock, idle low
o_mosi  out  1  card data in, idle high
o_cs  out  1  chip select, active low
o_busy  out  1  transaction in progress
o_done  out  1  one-cycle completion pulse
o_timeout  out  1  valid with o_done; 1 = no start bit within NCR_MAX slots
o_response  out  8*RESP_MAX_BYTES  response, right-aligned; first byte received is most significant

Behaviour:
- Reset (async, any time, including mid-transfer): state IDLE, o_sck=0, o_mosi=1, o_cs=1, o_busy=0, o_done=0, o_timeout=0, o_response all ones. No partial results survive.
- Slot timing: SCK low for the first CLK_DIV cycles of a slot and high for the remaining CLK_DIV cycles. MOSI changes only at slot start, while SCK is low. i_miso is sampled on the i_clk edge that drives o_sck 0->1.
- IDLE: if i_we=1, latch cmd/arg/crc, the clamped length, and hold_cs. On the next cycle: o_cs=0, o_busy=1, enter SEND. If CS is already low from a held command, it stays low.
- SEND: 48 slots, MSB first (i_cmd[7] first, i_crc[0] last).
- GAP: GAP_BITS slots with MOSI=1; samples are discarded.
- SEEK: MOSI=1. Each sample is checked; the first sample equal to 0 is bit 7 of response byte 0 and moves the engine to RECV, with no byte alignment to SEND required. If NCR_MAX slots pass with no 0 sample, go to END with the timeout flag set.
- RECV: MOSI=1. Capture the remaining 8*len-1 bits MSB first, then go to END.
- END:
  - If hold_cs=0: o_cs=1, then TRAIL_BITS slots with MOSI=1.
  - If hold_cs=1: CS stays low and the trailing slots are skipped.
  - Then, in the same cycle: o_done=1 for one cycle, o_busy=0, o_response and o_timeout update, and the state returns to IDLE.
- o_response on success: low 8*len bits hold the response; bits above are 0. On timeout: all ones, o_timeout=1.
- o_response and o_timeout hold their values until the next o_done or reset.
- i_we while o_busy=1 is ignored (no queueing). i_we in the cycle o_done is asserted is also ignored; it is accepted from the next cycle on.
- Command-to-first-response-bit latency (CLK_DIV=1, card answers in the first SEEK slot): 1 + 2*(48+GAP_BITS) cycles.
- o_sck returns to 0 at the end of every slot and is 0 in IDLE.

Test Plan:
- CMD0 (i_cmd=0x40, arg=0, crc=0x95, len=1, hold=0, CLK_DIV=1): card returns 0xFF, 0xFF, then 0x01 -> the MOSI bit stream equals 0x400000000095. After the response, CS rises and 8 trailing slots occur. Then o_done pulses with o_response=0x0000000001 and o_timeout=0.
- CMD8 (0x48, arg=0x000001AA, crc=0x87, len=5): card sends 0x01 00 00 01 AA after 3 idle bits, so the start bit is not byte-aligned -> o_response=0x01000001AA.
- i_miso held at 1 -> exactly NCR_MAX SEEK slots, then o_done with o_timeout=1 and o_response=0xFFFFFFFFFF; CS is high afterwards.
- hold_cs=1: CMD55 followed by ACMD41, each answered 0x01 -> o_cs stays 0 across both transactions, with no trailing slots between them. Then issue a command with hold_cs=0 -> CS rises.
- CLK_DIV=3: check that the SCK high and low phases are each 3 cycles, that MOSI is stable while SCK is high, and that the captured response is correct.
- Assert i_rst at slot 20 of SEND -> outputs take their reset values immediately. i_we pulses while busy are ignored. A new command after reset completes normally.

Source files
------------

// File: rtl/spi_cmd_resp_sdc.sv
// SD-card SPI command engine: generates mode-0 SCK, shifts out a 48-bit command,
// hunts for the response start bit within NCR_MAX slots and captures an R1/R3/R7 response.
module spi_cmd_resp_sdc #(
  parameter int CLK_DIV        = 1,
  parameter int GAP_BITS       = 8,
  parameter int NCR_MAX        = 64,
  parameter int RESP_MAX_BYTES = 5,
  parameter int TRAIL_BITS     = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_we,
  input  logic [7:0]                  i_cmd,
  input  logic [31:0]                 i_arg,
  input  logic [7:0]                  i_crc,
  input  logic [2:0]                  i_resp_len,
  input  logic                        i_hold_cs,
  input  logic                        i_miso,
  output logic                        o_sck,
  output logic                        o_mosi,
  output logic                        o_cs,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_timeout,
  output logic [8*RESP_MAX_BYTES-1:0] o_response
);

  localparam int RESP_W = 8 * RESP_MAX_BYTES;
  localparam int DIV_W  = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] SCK_HI    = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] SLOT_END  = DIV_W'(2 * CLK_DIV - 1);

  localparam logic [15:0] SEND_LAST  = 16'd47;
  localparam logic [15:0] GAP_LAST   = 16'(GAP_BITS - 1);
  localparam logic [15:0] NCR_LAST   = 16'(NCR_MAX - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(TRAIL_BITS - 1);
  localparam logic [2:0]  LEN_MAX    = 3'(RESP_MAX_BYTES);
  localparam bit          HAS_TRAIL  = (TRAIL_BITS > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_GAP, S_SEEK, S_RECV, S_TRAIL
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                cs_q, cs_d;
  logic                done_q, done_d;
  logic                to_q, to_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic [2:0]          len_q, len_d;
  logic                hold_q, hold_d;
  logic                found_q, found_d;
  logic [47:0]         cmd_sh_q, cmd_sh_d;
  logic [RESP_W-1:0]   rx_sh_q, rx_sh_d;

  logic                busy;
  logic                slot_end;
  logic                sample;
  logic                end_req;
  logic                complete;
  logic [2:0]          len_clamp;
  logic [15:0]         recv_last;

  assign busy      = (state_q != S_IDLE);
  assign slot_end  = busy && (div_q == SLOT_END);
  assign sample    = busy && (div_q == SAMPLE_AT);
  // The start bit is already one of the 8*len bits, so RECV shifts 8*len-1 more.
  assign recv_last = {10'd0, len_q, 3'b000} - 16'd2;

  always_comb begin
    len_clamp = i_resp_len;
    if (i_resp_len == 3'd0) begin
      len_clamp = 3'd1;
    end else if (i_resp_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    done_d   = 1'b0;
    to_d     = to_q;
    resp_d   = resp_q;
    len_d    = len_q;
    hold_d   = hold_q;
    found_d  = found_q;
    cmd_sh_d = cmd_sh_q;
    rx_sh_d  = rx_sh_q;
    end_req  = 1'b0;
    complete = 1'b0;

    if (busy) begin
      div_d = slot_end ? '0 : div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // A start request coinciding with the completion pulse is dropped.
        if (i_we && !done_q) begin
          state_d  = S_SEND;
          div_d    = '0;
          cnt_d    = '0;
          cs_d     = 1'b0;
          len_d    = len_clamp;
          hold_d   = i_hold_cs;
          found_d  = 1'b0;
          cmd_sh_d = {i_cmd, i_arg, i_crc};
          rx_sh_d  = '0;
        end
      end
      S_SEND: begin
        if (slot_end) begin
          cmd_sh_d = {cmd_sh_q[46:0], 1'b1};
          if (cnt_q == SEND_LAST) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (slot_end) begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_SEEK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_SEEK: begin
        // The start bit is 0 and rx_sh_q is cleared, so nothing needs shifting here.
        if (sample && !i_miso) begin
          found_d = 1'b1;
        end
        if (slot_end) begin
          if (found_q) begin
            state_d = S_RECV;
            cnt_d   = '0;
          end else if (cnt_q == NCR_LAST) begin
            end_req = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_RECV: begin
        if (sample) begin
          rx_sh_d = {rx_sh_q[RESP_W-2:0], i_miso};
        end
        if (slot_end) begin
          if (cnt_q == recv_last) begin
            end_req = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_TRAIL: begin
        if (slot_end) begin
          if (cnt_q == TRAIL_LAST) begin
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_req) begin
      if (!hold_q) begin
        cs_d = 1'b1;
      end
      if (!hold_q && HAS_TRAIL) begin
        state_d = S_TRAIL;
        cnt_d   = '0;
      end else begin
        complete = 1'b1;
      end
    end

    // found_q survives the trailing slots and distinguishes success from timeout.
    if (complete) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      to_d    = !found_q;
      resp_d  = found_q ? rx_sh_q : '1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      resp_q  <= '1;
      len_q   <= 3'd1;
      hold_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      to_q    <= to_d;
      resp_q  <= resp_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      found_q <= found_d;
    end
  end

  // Shift registers are reloaded on every accepted command.
  always_ff @(posedge i_clk) begin
    cmd_sh_q <= cmd_sh_d;
    rx_sh_q  <= rx_sh_d;
  end

  assign o_sck      = busy && (div_q >= SCK_HI);
  assign o_mosi     = (state_q == S_SEND) ? cmd_sh_q[47] : 1'b1;
  assign o_cs       = cs_q;
  assign o_busy     = busy;
  assign o_done     = done_q;
  assign o_timeout  = to_q;
  assign o_response = resp_q;

endmodule

// File: tb/tb_spi_cmd_resp_sdc.sv
// Scoreboard bench for spi_cmd_resp_sdc: a card model answers on MISO, a reference model
// predicts each transaction, and a monitor checks every o_done pulse (CLK_DIV=1 and 3 DUTs).
module tb_spi_cmd_resp_sdc;

  localparam int G     = 8;
  localparam int NCR   = 64;
  localparam int TRAIL = 8;
  localparam int RB    = 5;
  localparam int RW    = 8 * RB;

  typedef struct {
    logic [RW-1:0] resp;
    logic          to;
    logic          cs;
    int            rlo;
    int            rhi;
    logic [47:0]   frame;
    int            t_done;
    int            base_lo;
    int            base_hi;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic we   = 1'b0;
  logic sel  = 1'b0;
  logic hold = 1'b0;
  logic miso = 1'b1;
  logic [7:0]  cmd  = '0;
  logic [7:0]  crc  = '0;
  logic [31:0] arg  = '0;
  logic [2:0]  rlen = '0;

  logic sck1, mosi1, cs1, busy1, done1, to1;
  logic sck3, mosi3, cs3, busy3, done3, to3;
  logic [RW-1:0] resp1, resp3;
  logic we1, we3;
  logic sck_m, mosi_m, cs_m, busy_m, done_m, to_m;
  logic [RW-1:0] resp_m;

  assign we1    = we & ~sel;
  assign we3    = we & sel;
  assign sck_m  = sel ? sck3  : sck1;
  assign mosi_m = sel ? mosi3 : mosi1;
  assign cs_m   = sel ? cs3   : cs1;
  assign busy_m = sel ? busy3 : busy1;
  assign done_m = sel ? done3 : done1;
  assign to_m   = sel ? to3   : to1;
  assign resp_m = sel ? resp3 : resp1;

  spi_cmd_resp_sdc #(.CLK_DIV(1), .GAP_BITS(G), .NCR_MAX(NCR), .RESP_MAX_BYTES(RB), .TRAIL_BITS(TRAIL)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_we(we1), .i_cmd(cmd), .i_arg(arg), .i_crc(crc),
    .i_resp_len(rlen), .i_hold_cs(hold), .i_miso(miso), .o_sck(sck1), .o_mosi(mosi1),
    .o_cs(cs1), .o_busy(busy1), .o_done(done1), .o_timeout(to1), .o_response(resp1));

  spi_cmd_resp_sdc #(.CLK_DIV(3), .GAP_BITS(G), .NCR_MAX(NCR), .RESP_MAX_BYTES(RB), .TRAIL_BITS(TRAIL)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_we(we3), .i_cmd(cmd), .i_arg(arg), .i_crc(crc),
    .i_resp_len(rlen), .i_hold_cs(hold), .i_miso(miso), .o_sck(sck3), .o_mosi(mosi3),
    .o_cs(cs3), .o_busy(busy3), .o_done(done3), .o_timeout(to3), .o_response(resp3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Card: MISO stream indexed by SCK slot number since the command was issued.
  bit card_q[$];
  int base_lo = 0, base_hi = 0;
  int nrise_lo = 0, nrise_hi = 0;
  logic [47:0] frame = '0;

  function automatic bit card_bit(input int k);
    if (k < 48) return 1'b1;
    if (k - 48 < card_q.size()) return card_q[k-48];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge sck_m);
    if (!cs_m) begin
      if (nrise_lo - base_lo < 48) frame = {frame[46:0], mosi_m};
      nrise_lo = nrise_lo + 1;
    end else begin
      nrise_hi = nrise_hi + 1;
    end
  end

  initial forever begin
    @(negedge sck_m);
    miso = card_bit(nrise_lo - base_lo);
  end

  // Reference: bit k of the card's answer counted from the first slot after the command.
  function automatic bit sbit(input int k, input int delay, input logic [39:0] data, input int nb);
    int j;
    j = k - delay;
    if (j < 0) return 1'b1;
    if (j < 8 * nb) return data[39-j];
    return 1'b1;
  endfunction

  function automatic exp_t model(input logic [7:0] c, input logic [31:0] a, input logic [7:0] r,
                                 input int ln, input bit h, input int delay, input logic [39:0] data,
                                 input int nb, input int div, input int t0);
    exp_t e;
    int L, p, seek, recv;
    p = -1;
    L = (ln == 0) ? 1 : ((ln > RB) ? RB : ln);
    for (int k = G; k < G + NCR; k++) if (p < 0 && sbit(k, delay, data, nb) == 1'b0) p = k;
    if (p >= 0) begin
      e.resp = '0;
      for (int i = 0; i < 8 * L; i++) e.resp = {e.resp[RW-2:0], sbit(p + i, delay, data, nb)};
      e.to = 1'b0;
      seek = p - G + 1;
      recv = 8 * L - 1;
    end else begin
      e.resp = '1;
      e.to   = 1'b1;
      seek   = NCR;
      recv   = 0;
    end
    e.rlo     = 48 + G + seek + recv;
    e.rhi     = h ? 0 : TRAIL;
    e.cs      = h ? 1'b0 : 1'b1;
    e.frame   = {c, a, r};
    e.t_done  = t0 + 2 * div * (e.rlo + e.rhi) + 1;
    e.base_lo = 0;
    e.base_hi = 0;
    return e;
  endfunction

  // Monitor: one scoreboard entry per completion pulse.
  initial forever begin : mon
    exp_t e;
    @(negedge clk);
    if (!rst && done_m) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got response %0h expected no completion", resp_m);
      end else begin
        e = sbq.pop_front();
        chk("response", 64'(resp_m), 64'(e.resp));
        chk("timeout", 64'(to_m), 64'(e.to));
        chk("cs_at_done", 64'(cs_m), 64'(e.cs));
        chk("busy_at_done", 64'(busy_m), 64'd0);
        chk("mosi_frame", 64'(frame), 64'(e.frame));
        chk("slots_cs_low", 64'(nrise_lo - e.base_lo), 64'(e.rlo));
        chk("slots_trailing", 64'(nrise_hi - e.base_hi), 64'(e.rhi));
        chk("done_cycle", 64'(cyc), 64'(e.t_done));
      end
    end
  end

  // SCK phase lengths and MOSI stability while SCK is high.
  initial begin : phase
    logic prev_sck, prev_mosi, lo_valid;
    int run, div;
    prev_sck = 1'b0; prev_mosi = 1'b1; lo_valid = 1'b0; run = 0;
    forever begin
      @(negedge clk);
      div = sel ? 3 : 1;
      if (rst) begin
        prev_sck = 1'b0; lo_valid = 1'b0; run = 0;
      end else begin
        if (sck_m && prev_sck) chk("mosi_stable_sck_high", 64'(mosi_m), 64'(prev_mosi));
        if (sck_m != prev_sck) begin
          if (prev_sck) begin
            chk("sck_high_len", 64'(run), 64'(div));
            lo_valid = 1'b1;
          end else if (lo_valid) begin
            chk("sck_low_len", 64'(run), 64'(div));
          end
          run = 1;
        end else begin
          run = run + 1;
        end
        if (!busy_m) lo_valid = 1'b0;
        prev_sck  = sck_m;
        prev_mosi = mosi_m;
      end
    end
  end

  task automatic do_cmd(input bit s, input logic [7:0] c, input logic [31:0] a, input logic [7:0] r,
                        input logic [2:0] ln, input bit h, input int delay, input logic [39:0] data,
                        input int nb);
    exp_t e;
    bit seen;
    @(negedge clk);
    sel = s;
    card_q.delete();
    for (int k = 0; k < delay; k++) card_q.push_back(1'b1);
    for (int j = 0; j < 8 * nb; j++) card_q.push_back(data[39-j]);
    base_lo = nrise_lo;
    base_hi = nrise_hi;
    e = model(c, a, r, int'(ln), h, delay, data, nb, s ? 3 : 1, cyc);
    e.base_lo = base_lo;
    e.base_hi = base_hi;
    sbq.push_back(e);
    cmd = c; arg = a; crc = r; rlen = ln; hold = h; we = 1'b1;
    @(negedge clk);
    we = 1'b0; cmd = ~c; arg = ~a; crc = ~r; rlen = ~ln; hold = ~h;
    repeat (5) @(negedge clk);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done_m) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_wait got no o_done expected one within 20000 cycles");
      sbq.delete();
      return;
    end
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("we_in_done_cycle_ignored", 64'(busy_m), 64'd0);
    chk("cs_after_done", 64'(cs_m), 64'(!h));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({sck_m, mosi_m, cs_m, busy_m, done_m, to_m}), 64'(6'b011000));
    chk({tag, "_resp"}, 64'(resp_m), 64'({RW{1'b1}}));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [39:0] d;
    bit ok;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1 chk_reset("reset_dut1");
    sel = 1'b1; #1 chk_reset("reset_dut3");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // CMD0, CMD8 with an unaligned start bit, and a timeout
    do_cmd(0, 8'h40, 32'h0, 8'h95, 3'd1, 0, G + 8, 40'h01_0000_0000, 1);
    do_cmd(0, 8'h48, 32'h0000_01AA, 8'h87, 3'd5, 0, G + 3, 40'h01_0000_01AA, 5);
    do_cmd(0, 8'h7A, 32'h0, 8'hFD, 3'd5, 0, G, 40'h0, 0);
    // length clamping: 0 behaves as 1, 7 behaves as 5
    do_cmd(0, 8'h4D, 32'h0, 8'h0D, 3'd0, 0, G + 1, 40'h05_3C00_0000, 2);
    do_cmd(0, 8'h4A, 32'h0, 8'h1B, 3'd7, 0, G + 5, 40'h00_FF12_3456, 5);
    // start bit in the very first and very last SEEK slot
    do_cmd(0, 8'h40, 32'h0, 8'h95, 3'd1, 0, G, 40'h01_0000_0000, 1);
    do_cmd(0, 8'h40, 32'h0, 8'h95, 3'd1, 0, G + NCR - 1, 40'h01_0000_0000, 1);
    // held CS across CMD55 / ACMD41, then release
    do_cmd(0, 8'h77, 32'h0, 8'h65, 3'd1, 1, G + 8, 40'h01_0000_0000, 1);
    do_cmd(0, 8'h69, 32'h4000_0000, 8'h77, 3'd1, 1, G + 8, 40'h01_0000_0000, 1);
    do_cmd(0, 8'h50, 32'h0000_0200, 8'h15, 3'd1, 0, G + 2, 40'h00_0000_0000, 1);

    for (int n = 0; n < 16; n++) begin
      d = {$urandom, 8'($urandom)};
      d[39] = 1'b0;
      do_cmd(0, {2'b01, 6'($urandom)}, $urandom, 8'($urandom), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0), G + $urandom_range(0, NCR + 4), d, $urandom_range(1, 5));
    end
    do_cmd(0, 8'h40, 32'h0, 8'h95, 3'd1, 0, G + 8, 40'h01_0000_0000, 1);

    // CLK_DIV=3 instance
    do_cmd(1, 8'h48, 32'h0000_01AA, 8'h87, 3'd5, 0, G + 3, 40'h01_0000_01AA, 5);
    for (int n = 0; n < 4; n++) begin
      d = {$urandom, 8'($urandom)};
      d[39] = 1'b0;
      do_cmd(1, {2'b01, 6'($urandom)}, $urandom, 8'($urandom), 3'($urandom_range(1, 5)),
             1'b0, G + $urandom_range(0, 20), d, 5);
    end

    // reset in slot 20 of SEND
    @(negedge clk);
    sel = 1'b0;
    card_q.delete();
    base_lo = nrise_lo;
    base_hi = nrise_hi;
    cmd = 8'h51; arg = 32'h1234_5678; crc = 8'hFF; rlen = 3'd1; hold = 1'b0; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (nrise_lo - base_lo >= 21) ok = 1'b1;
    end
    chk("reached_send_slot20", 64'(ok), 64'd1);
    #1 rst = 1'b1;
    #1 chk_reset("reset_mid_send");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_cmd(0, 8'h40, 32'h0, 8'h95, 3'd1, 0, G + 8, 40'h01_0000_0000, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
